music_player: RTL and testbench

Streaming reader for the music sample ROM. It steps the ROM address at the audio sample rate and captures each sample, accounting for the ROM's one-cycle registered read latency. It presents each sample to the downstream audio transmitter over a valid/ready handshake. It sits between the `music` ROM (drives its `Add`, consumes its `music_content`) and the codec/I2S serializer.

---
 rtl/music_player_if.sv | 22 ++
 rtl/music_player.sv | 129 ++++++++++++
 tb/tb_music_player.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/music_player_if.sv
// ROM read bus and sample stream between the music player and its neighbours:
// the player drives the ROM address and offers captured samples downstream.
interface music_player_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 17
);
  logic [ADDR_W-1:0] Add;
  logic [DATA_W-1:0] music_content;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output Add, sample_out, sample_valid,
    input  music_content, sample_ready
  );

  modport slave (
    input  Add, sample_out, sample_valid,
    output music_content, sample_ready
  );
endinterface

// File: rtl/music_player.sv
// Streams samples out of the registered-read music ROM at the audio sample rate
// and offers each one to the audio transmitter over a valid/ready handshake.
module music_player #(
  parameter int unsigned DEPTH      = 43114,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 17,
  parameter int unsigned SAMPLE_DIV = 1042
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  music_player_if.master      bus,
  output logic                playing,
  output logic                done,
  output logic                underrun
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);
  localparam logic [ADDR_W-1:0] LAST_ADD = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  DIV_MAX  = CNT_W'(SAMPLE_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    OFFER,
    WAIT_TICK
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  div_cnt, cnt_nx;
  logic              tick_pending, pending_nx;
  logic              underrun_nx, done_nx;
  logic [ADDR_W-1:0] add_nx;
  logic [DATA_W-1:0] sample_nx;
  logic              tick;
  logic              xfer;

  assign playing          = (state != IDLE);
  assign bus.sample_valid = (state == OFFER);

  always_comb begin
    tick        = (state != IDLE) && (div_cnt == DIV_MAX);
    xfer        = (state == OFFER) && bus.sample_ready;
    state_nx    = state;
    add_nx      = bus.Add;
    sample_nx   = bus.sample_out;
    done_nx     = 1'b0;
    pending_nx  = tick_pending;
    underrun_nx = underrun;
    cnt_nx      = div_cnt;

    if (state != IDLE) begin
      cnt_nx = (div_cnt == DIV_MAX) ? '0 : div_cnt + CNT_W'(1);
    end
    if (tick && tick_pending) underrun_nx = 1'b1;
    if (tick && state != WAIT_TICK) pending_nx = 1'b1;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nx    = ISSUE;
          add_nx      = '0;
          cnt_nx      = '0;
          pending_nx  = 1'b0;
          underrun_nx = 1'b0;
        end
      end
      ISSUE:   state_nx = CAPTURE;
      CAPTURE: begin
        sample_nx = bus.music_content;
        state_nx  = OFFER;
      end
      OFFER: begin
        if (xfer) begin
          if (bus.Add == LAST_ADD) begin
            add_nx = '0;
            if (loop_en) begin
              state_nx = WAIT_TICK;
            end else begin
              state_nx = IDLE;
              done_nx  = 1'b1;
            end
          end else begin
            add_nx   = bus.Add + ADDR_W'(1);
            state_nx = WAIT_TICK;
          end
        end
      end
      WAIT_TICK: begin
        if (tick_pending || tick) begin
          pending_nx = 1'b0;
          state_nx   = ISSUE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Abort overrides whatever the current state decided, including the end-of-track pulse.
    if (stop && state != IDLE) begin
      state_nx = IDLE;
      add_nx   = '0;
      done_nx  = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= IDLE;
      bus.Add        <= '0;
      bus.sample_out <= '0;
      div_cnt        <= '0;
      tick_pending   <= 1'b0;
      underrun       <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nx;
      bus.Add        <= add_nx;
      bus.sample_out <= sample_nx;
      div_cnt        <= cnt_nx;
      tick_pending   <= pending_nx;
      underrun       <= underrun_nx;
      done           <= done_nx;
    end
  end

endmodule

// File: tb/tb_music_player.sv
// Self-checking bench for music_player: a timing model driven by sample-period
// arithmetic is compared every cycle, plus hand-computed literal expectations.
module tb_music_player;

  localparam int DEPTH  = 6;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 12;
  localparam int DIV    = 8;

  logic Clk = 1'b0;
  logic Reset, start, stop, loop_en;
  logic playing, done, underrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  music_player_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  music_player #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SAMPLE_DIV(DIV)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .stop(stop), .loop_en(loop_en),
    .bus(bus), .playing(playing), .done(done), .underrun(underrun)
  );

  always #5 Clk = ~Clk;

  // ROM with one cycle of registered read latency; mem[i] = i + 100
  always @(posedge Clk) bus.music_content <= DATA_W'(int'(bus.Add) + 100);

  // Model: expected outputs for the upcoming cycle
  bit m_play, m_valid, m_wait, m_done, m_under;
  int m_addr, m_out, m_offer_at, m_bank, m_start;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Advance the model across the coming clock edge using the inputs now applied.
  task automatic model_step();
    int c;
    bit tk;
    c  = cyc;
    tk = m_play && (c > m_start) && (((c - m_start) % DIV) == 0);
    m_done = 1'b0;
    if (Reset) begin
      m_play = 0; m_valid = 0; m_wait = 0; m_addr = 0; m_out = 0;
      m_under = 0; m_bank = 0;
    end else if (!m_play) begin
      if (start && !stop) begin
        m_play = 1; m_start = c; m_addr = 0; m_offer_at = c + 3;
        m_wait = 0; m_valid = 0; m_bank = 0; m_under = 0;
      end
    end else begin
      if (tk && m_bank != 0) m_under = 1;
      if (stop) begin
        m_play = 0; m_valid = 0; m_wait = 0; m_addr = 0;
      end else if (m_wait) begin
        if (tk || m_bank != 0) begin
          m_bank = 0; m_wait = 0; m_offer_at = c + 3;
        end
      end else begin
        if (tk) m_bank = 1;
        if (m_valid && bus.sample_ready) begin
          m_valid = 0;
          if (m_addr == DEPTH - 1 && !loop_en) begin
            m_play = 0; m_done = 1; m_addr = 0;
          end else begin
            m_addr = (m_addr == DEPTH - 1) ? 0 : m_addr + 1;
            m_wait = 1;
          end
        end else if (!m_valid && c + 1 == m_offer_at) begin
          m_valid = 1;
          m_out   = m_addr + 100;
        end
      end
    end
    cyc++;
  endtask

  task automatic compare_all();
    chk("sample_valid", int'(bus.sample_valid), int'(m_valid));
    chk("playing", int'(playing), int'(m_play));
    chk("done", int'(done), int'(m_done));
    chk("underrun", int'(underrun), int'(m_under));
    chk("Add", int'(bus.Add), m_addr);
    if (m_valid) chk("sample_out", int'(bus.sample_out), m_out);
  endtask

  task automatic cyc_step(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(negedge Clk);
      compare_all();
    end
  endtask

  task automatic wait_sample(input int val, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (bus.sample_valid && int'(bus.sample_out) == val) return;
      cyc_step(1);
    end
    chk("wait_sample_timeout", int'(bus.sample_out), val);
  endtask

  initial begin
    int held;
    int ndone;
    Reset = 1; start = 0; stop = 0; loop_en = 1; bus.sample_ready = 1;
    cyc_step(3);
    chk("rst_Add", int'(bus.Add), 0);
    chk("rst_valid", int'(bus.sample_valid), 0);
    chk("rst_playing", int'(playing), 0);
    Reset = 0;
    cyc_step(2);

    // Steady play with looping: first sample 3 cycles after start, then every DIV
    start = 1; cyc_step(1); start = 0;
    cyc_step(2);
    chk("first_valid", int'(bus.sample_valid), 1);
    chk("first_sample", int'(bus.sample_out), 100);
    cyc_step(7);
    chk("gap_valid", int'(bus.sample_valid), 0);
    cyc_step(1);
    chk("second_valid", int'(bus.sample_valid), 1);
    chk("second_sample", int'(bus.sample_out), 101);
    chk("second_Add", int'(bus.Add), 1);
    start = 1; cyc_step(1); start = 0;
    cyc_step(60);

    // Stop during OFFER
    wait_sample(int'(bus.sample_out) == 100 + DEPTH - 1 ? 100 : int'(bus.sample_out) + 1, 20);
    held = int'(bus.sample_out);
    stop = 1; cyc_step(1); stop = 0;
    chk("stop_valid", int'(bus.sample_valid), 0);
    chk("stop_playing", int'(playing), 0);
    chk("stop_Add", int'(bus.Add), 0);
    chk("stop_hold", int'(bus.sample_out), held);

    // start and stop together in IDLE
    start = 1; stop = 1; cyc_step(1); start = 0; stop = 0;
    chk("race_playing", int'(playing), 0);
    cyc_step(2);
    chk("race_playing_later", int'(playing), 0);

    // Backpressure on sample 3
    start = 1; cyc_step(1); start = 0;
    wait_sample(103, 40);
    bus.sample_ready = 0;
    cyc_step(8);
    chk("bp_underrun_early", int'(underrun), 0);
    cyc_step(12);
    chk("bp_hold", int'(bus.sample_out), 103);
    chk("bp_underrun", int'(underrun), 1);
    bus.sample_ready = 1;
    cyc_step(4);
    chk("bp_next_sample", int'(bus.sample_out), 104);
    chk("bp_next_valid", int'(bus.sample_valid), 1);

    // End of track without looping
    stop = 1; cyc_step(1); stop = 0;
    loop_en = 0;
    start = 1; cyc_step(1); start = 0;
    chk("eot_underrun_cleared", int'(underrun), 0);
    ndone = 0;
    for (int i = 0; i < 70; i++) begin
      cyc_step(1);
      if (done) ndone++;
    end
    chk("eot_done_count", ndone, 1);
    chk("eot_playing", int'(playing), 0);
    chk("eot_Add", int'(bus.Add), 0);

    // Reset mid-OFFER
    loop_en = 1;
    start = 1; cyc_step(1); start = 0;
    wait_sample(100, 10);
    Reset = 1; cyc_step(1);
    chk("mid_rst_valid", int'(bus.sample_valid), 0);
    chk("mid_rst_playing", int'(playing), 0);
    cyc_step(1); Reset = 0;
    chk("mid_rst_Add", int'(bus.Add), 0);
    chk("mid_rst_underrun", int'(underrun), 0);
    chk("mid_rst_done", int'(done), 0);
    cyc_step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
